gx4000_asic_ram_arbiter: RTL and testbench

Single-port access controller for the 16 KB Plus ASIC register RAM. It shares the RAM between three requesters: video/sprite fetch, the CPU window at 0x4000–0x7FFF, and the audio DMA list reader. It enforces the ASIC lock state on CPU traffic and routes read data back to the requester that issued the read. It sits between the requesters and the RAM's external port (addr/rd/wr/din/q).

---
 rtl/gx4000_asic_ram_arbiter_if.sv | 40 ++++
 rtl/gx4000_asic_ram_arbiter.sv | 104 ++++++++++
 tb/tb_gx4000_asic_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gx4000_asic_ram_arbiter_if.sv
// gx4000_asic_ram_arbiter_if: requester, RAM port and debug signals of the ASIC RAM arbiter
interface gx4000_asic_ram_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wr_blocked;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_ack;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd;
  logic          ram_wr;
  logic [DW-1:0] ram_q;
  logic [1:0]    grant_owner;
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, ram_q,
    output vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata, cpu_wr_blocked,
           dma_ack, dma_rvalid, dma_rdata, ram_addr, ram_din, ram_rd, ram_wr, grant_owner
  );
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, ram_q,
    input  vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata, cpu_wr_blocked,
           dma_ack, dma_rvalid, dma_rdata, ram_addr, ram_din, ram_rd, ram_wr, grant_owner
  );
endinterface

// File: rtl/gx4000_asic_ram_arbiter.sv
// gx4000_asic_ram_arbiter: shares the Plus ASIC register RAM between video, CPU and audio DMA
module gx4000_asic_ram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic plus_mode,
  input  logic asic_valid,
  gx4000_asic_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_t;
  typedef struct packed {
    owner_t owner;
    logic   is_read;
    logic   locked;
  } tag_t;
  owner_t        win;
  tag_t          tag1;
  tag_t          tag2;
  logic [3:0]    dma_wait;
  logic          vid_elig;
  logic          cpu_elig;
  logic          dma_elig;
  logic          dma_starved;
  logic          locked;
  logic          win_read;
  logic          win_locked;
  logic          mem_cmd;
  logic          to_vid;
  logic          to_cpu;
  logic          to_dma;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] read_data;
  // arbitration: video first, a starved DMA next, then CPU, then DMA; decode of the winning command
  always_comb begin
    vid_elig = plus_mode && bus.vid_req && !bus.vid_ack;
    cpu_elig = bus.cpu_req && !bus.cpu_ack;
    dma_elig = plus_mode && bus.dma_req && !bus.dma_ack;
    dma_starved = int'(dma_wait) >= STARVE_LIMIT;
    locked = !asic_valid || !plus_mode;
    win = vid_elig ? OWN_VID : (dma_elig && dma_starved) ? OWN_DMA : cpu_elig ? OWN_CPU : dma_elig ? OWN_DMA : OWN_NONE;
    win_read = win != OWN_NONE && !(win == OWN_CPU && bus.cpu_we);
    win_locked = win == OWN_CPU && locked;
    mem_cmd = win != OWN_NONE && !win_locked;
    win_addr = win == OWN_VID ? bus.vid_addr : win == OWN_CPU ? bus.cpu_addr : bus.dma_addr;
    read_data = tag2.locked ? '1 : bus.ram_q;
    to_vid = tag2.is_read && tag2.owner == OWN_VID;
    to_cpu = tag2.is_read && tag2.owner == OWN_CPU;
    to_dma = tag2.is_read && tag2.owner == OWN_DMA;
  end
  // command stage: acks, RAM strobes and the first tag stage one cycle after the win
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      bus.cpu_wr_blocked <= 1'b0;
      bus.ram_rd <= 1'b0;
      bus.ram_wr <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din <= '0;
      bus.grant_owner <= 2'd0;
      tag1 <= '0;
    end else begin
      bus.vid_ack <= win == OWN_VID;
      bus.cpu_ack <= win == OWN_CPU;
      bus.dma_ack <= win == OWN_DMA;
      bus.cpu_wr_blocked <= win_locked && !win_read;
      bus.ram_rd <= mem_cmd && win_read;
      bus.ram_wr <= mem_cmd && !win_read;
      bus.ram_addr <= mem_cmd ? win_addr : bus.ram_addr;
      bus.ram_din <= (mem_cmd && !win_read) ? bus.cpu_wdata : bus.ram_din;
      bus.grant_owner <= win;
      tag1 <= '{owner: win_read ? win : OWN_NONE, is_read: win_read, locked: win_locked};
    end
  end
  // DMA starvation counter: saturating, cleared on a DMA grant or when DMA stops asking
  always_ff @(posedge clk_sys) begin
    if (reset) dma_wait <= '0;
    else dma_wait <= (!(plus_mode && bus.dma_req) || win == OWN_DMA) ? '0 : dma_wait + {3'b0, dma_wait != 4'hF};
  end
  // response stage: read data goes only to the owner tagged two cycles back, others hold
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tag2 <= '0;
      bus.vid_rvalid <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.vid_rdata <= '0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      tag2 <= tag1;
      bus.vid_rvalid <= to_vid;
      bus.cpu_rvalid <= to_cpu;
      bus.dma_rvalid <= to_dma;
      bus.vid_rdata <= to_vid ? read_data : bus.vid_rdata;
      bus.cpu_rdata <= to_cpu ? read_data : bus.cpu_rdata;
      bus.dma_rdata <= to_dma ? read_data : bus.dma_rdata;
    end
  end
endmodule

// File: tb/tb_gx4000_asic_ram_arbiter.sv
// tb_gx4000_asic_ram_arbiter: directed and random checks of the ASIC RAM arbiter against a cycle-schedule model
module tb_gx4000_asic_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int LIMIT = 8;
  typedef struct packed {
    logic [2:0]    ack;
    logic [1:0]    go;
    logic          rd;
    logic          wr;
    logic          blk;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    rv_own;
    logic [DW-1:0] rv_data;
  } exp_t;
  logic clk_sys = 1'b0;
  logic reset;
  logic plus_mode;
  logic asic_valid;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_wait = 0;
  int n;
  exp_t slot [4];
  logic [DW-1:0] last [4];
  logic [DW-1:0] mdl [1<<AW];
  logic [DW-1:0] ram [1<<AW];
  bit wrote [1<<AW];
  int seq [12] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 3, 1, 2};
  gx4000_asic_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  gx4000_asic_ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .plus_mode(plus_mode),
    .asic_valid(asic_valid),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  function automatic logic [7:0] f(input logic [13:0] a);
    return (a[7:0] * 8'd29) ^ {a[13:8], 2'b01};
  endfunction
  // RAM behind the arbiter: unwritten cells read as f(addr), one-cycle read latency
  always @(posedge clk_sys) begin
    if (bus.ram_wr) begin
      ram[bus.ram_addr] <= bus.ram_din;
      wrote[bus.ram_addr] <= 1'b1;
    end
    if (bus.ram_rd) bus.ram_q <= wrote[bus.ram_addr] ? ram[bus.ram_addr] : f(bus.ram_addr);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic acked(input int a);
    return slot[cyc % 4].ack[a-1];
  endfunction
  task automatic no_reqs();
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
  endtask
  task automatic cycle();
    exp_t s;
    logic [2:0] ak;
    logic ve, ce, de, lk;
    logic [AW-1:0] a;
    int w, n1, n3;
    s = slot[cyc % 4];
    chk("ack", {bus.dma_ack, bus.cpu_ack, bus.vid_ack}, s.ack);
    chk("grant_owner", bus.grant_owner, s.go);
    chk("ram_rd", bus.ram_rd, s.rd);
    chk("ram_wr", bus.ram_wr, s.wr);
    chk("cpu_wr_blocked", bus.cpu_wr_blocked, s.blk);
    if (s.rd || s.wr) chk("ram_addr", bus.ram_addr, s.addr);
    if (s.wr) chk("ram_din", bus.ram_din, s.din);
    if (s.rv_own != 2'd0) last[s.rv_own] = s.rv_data;
    chk("rvalid", {bus.dma_rvalid, bus.cpu_rvalid, bus.vid_rvalid}, s.rv_own == 2'd0 ? 3'b0 : 3'b1 << (s.rv_own - 2'd1));
    chk("vid_rdata", bus.vid_rdata, last[1]);
    chk("cpu_rdata", bus.cpu_rdata, last[2]);
    chk("dma_rdata", bus.dma_rdata, last[3]);
    ak = s.ack;
    slot[cyc % 4] = '0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        slot[i] = '0;
        last[i] = '0;
      end
      m_wait = 0;
    end else begin
      ve = plus_mode && bus.vid_req && !ak[0];
      ce = bus.cpu_req && !ak[1];
      de = plus_mode && bus.dma_req && !ak[2];
      w = ve ? 1 : (de && m_wait >= LIMIT) ? 3 : ce ? 2 : de ? 3 : 0;
      m_wait = (!(plus_mode && bus.dma_req) || w == 3) ? 0 : (m_wait < 15 ? m_wait + 1 : 15);
      lk = !asic_valid || !plus_mode;
      n1 = (cyc + 1) % 4;
      n3 = (cyc + 3) % 4;
      if (w != 0) begin
        slot[n1].ack[w-1] = 1'b1;
        slot[n1].go = 2'(w);
      end
      if (w == 1 || w == 3) begin
        a = w == 1 ? bus.vid_addr : bus.dma_addr;
        slot[n1].rd = 1'b1;
        slot[n1].addr = a;
        slot[n3].rv_own = 2'(w);
        slot[n3].rv_data = mdl[a];
      end else if (w == 2 && bus.cpu_we && lk) begin
        slot[n1].blk = 1'b1;
      end else if (w == 2 && bus.cpu_we) begin
        slot[n1].wr = 1'b1;
        slot[n1].addr = bus.cpu_addr;
        slot[n1].din = bus.cpu_wdata;
        mdl[bus.cpu_addr] = bus.cpu_wdata;
      end else if (w == 2) begin
        slot[n3].rv_own = 2'd2;
        slot[n3].rv_data = lk ? 8'hFF : mdl[bus.cpu_addr];
        slot[n1].rd = !lk;
        slot[n1].addr = bus.cpu_addr;
      end
    end
    cyc++;
    @(negedge clk_sys);
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) mdl[i] = f(14'(i));
    for (int i = 0; i < 4; i++) begin
      slot[i] = '0;
      last[i] = '0;
    end
    reset = 1'b1;
    plus_mode = 1'b1;
    asic_valid = 1'b1;
    no_reqs();
    bus.vid_addr = '0;
    bus.cpu_addr = '0;
    bus.dma_addr = '0;
    bus.cpu_we = 1'b0;
    bus.cpu_wdata = '0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    cycle();
    reset = 1'b0;
    repeat (2) cycle();
    // unlocked write then read back
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 14'h0123;
    bus.cpu_wdata = 8'h5A;
    cycle();
    chk("t1_ram_wr", bus.ram_wr, 1);
    chk("t1_ram_addr", bus.ram_addr, 14'h0123);
    chk("t1_ram_din", bus.ram_din, 8'h5A);
    bus.cpu_req = 1'b0;
    cycle();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    cycle();
    bus.cpu_req = 1'b0;
    repeat (2) cycle();
    chk("t1_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("t1_cpu_rdata", bus.cpu_rdata, 8'h5A);
    cycle();
    // locked write is dropped, locked read returns FF; unlocking after the grant changes nothing
    asic_valid = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 14'h0010;
    bus.cpu_wdata = 8'h77;
    cycle();
    chk("t2_cpu_ack", bus.cpu_ack, 1);
    chk("t2_blocked", bus.cpu_wr_blocked, 1);
    chk("t2_ram_wr", bus.ram_wr, 0);
    bus.cpu_req = 1'b0;
    cycle();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    cycle();
    chk("t2_ram_rd", bus.ram_rd, 0);
    bus.cpu_req = 1'b0;
    asic_valid = 1'b1;
    cycle();
    cycle();
    chk("t2_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("t2_cpu_rdata", bus.cpu_rdata, 8'hFF);
    repeat (2) cycle();
    // all three held with fresh addresses: video/CPU alternate until DMA starves
    bus.vid_req = 1'b1;
    bus.cpu_req = 1'b1;
    bus.dma_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.vid_addr = 14'($urandom_range(0, 63));
    bus.cpu_addr = 14'($urandom_range(0, 63));
    bus.dma_addr = 14'($urandom_range(0, 63));
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t3_seq", bus.grant_owner, seq[k]);
      if (acked(1)) bus.vid_addr = 14'($urandom_range(0, 63));
      if (acked(2)) bus.cpu_addr = 14'($urandom_range(0, 63));
      if (acked(3)) bus.dma_addr = 14'($urandom_range(0, 63));
    end
    no_reqs();
    repeat (4) cycle();
    // back-to-back video reads with a DMA read interleaved
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h0000;
    bus.dma_req = 1'b1;
    bus.dma_addr = 14'h0005;
    cycle();
    bus.vid_addr = 14'h0001;
    cycle();
    bus.dma_req = 1'b0;
    cycle();
    bus.vid_req = 1'b0;
    chk("t4_vid_rvalid0", bus.vid_rvalid, 1);
    chk("t4_vid_rdata0", bus.vid_rdata, f(14'h0000));
    chk("t4_dma_quiet", bus.dma_rvalid, 0);
    cycle();
    chk("t4_dma_rvalid", bus.dma_rvalid, 1);
    chk("t4_dma_rdata", bus.dma_rdata, f(14'h0005));
    chk("t4_vid_quiet", bus.vid_rvalid, 0);
    cycle();
    chk("t4_vid_rvalid1", bus.vid_rvalid, 1);
    chk("t4_vid_rdata1", bus.vid_rdata, f(14'h0001));
    chk("t4_dma_hold", bus.dma_rdata, f(14'h0005));
    repeat (2) cycle();
    // reset the cycle after a DMA ack discards the read
    bus.dma_req = 1'b1;
    bus.dma_addr = 14'h0007;
    cycle();
    chk("t5_dma_ack", bus.dma_ack, 1);
    bus.dma_req = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_ram_addr", bus.ram_addr, 0);
    chk("t5_ram_din", bus.ram_din, 0);
    chk("t5_dma_rdata", bus.dma_rdata, 0);
    n = 0;
    repeat (4) begin
      n += int'(bus.dma_rvalid);
      cycle();
    end
    chk("t5_no_dma_rvalid", n, 0);
    // plus_mode off: video ignored, CPU reads locked
    plus_mode = 1'b0;
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h0003;
    n = 0;
    repeat (20) begin
      n += int'(bus.vid_ack);
      cycle();
    end
    chk("t6_no_vid_ack", n, 0);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 14'h0020;
    cycle();
    bus.cpu_req = 1'b0;
    repeat (2) cycle();
    chk("t6_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("t6_cpu_rdata", bus.cpu_rdata, 8'hFF);
    bus.vid_req = 1'b0;
    plus_mode = 1'b1;
    repeat (2) cycle();
    // random traffic, lock/mode toggles and occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        no_reqs();
      end
      if ($urandom_range(0, 19) == 0) asic_valid = ~asic_valid;
      if ($urandom_range(0, 49) == 0) plus_mode = ~plus_mode;
      if (!reset) begin
        if (acked(1) || !bus.vid_req) begin
          bus.vid_req = $urandom_range(0, 99) < 50;
          bus.vid_addr = 14'($urandom_range(0, 63));
        end
        if (acked(2) || !bus.cpu_req) begin
          bus.cpu_req = $urandom_range(0, 99) < 50;
          bus.cpu_we = $urandom_range(0, 1) == 1;
          bus.cpu_addr = 14'($urandom_range(0, 63));
          bus.cpu_wdata = 8'($urandom);
        end
        if (acked(3) || !bus.dma_req) begin
          bus.dma_req = $urandom_range(0, 99) < 50;
          bus.dma_addr = 14'($urandom_range(0, 63));
        end
      end
      cycle();
    end
    reset = 1'b0;
    no_reqs();
    repeat (5) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
